// File: rtl/wb_regfile_unit_pkg.sv
// Shared widths, writeback-select and load funct3 encodings, FSM state type
// for the RV32I writeback / register-file unit.
package wb_regfile_unit_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_RSVD = 2'b11;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wbState_t;

endpackage

// File: rtl/wb_regfile_unit_load_align.sv
// Combinational load extractor: picks the addressed byte/halfword out of a
// memory word and sign- or zero-extends it according to funct3.
module wb_regfile_unit_load_align
    import wb_regfile_unit_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] value
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // off[0] is deliberately ignored for halfwords: no misalignment trap.
    assign byteSel = word[{off, 3'b000} +: 8];
    assign halfSel = off[1] ? word[31:16] : word[15:0];

    always_comb begin
        value = word;
        unique case (funct3)
            FUNCT3_LB:  value = {{24{byteSel[7]}}, byteSel};
            FUNCT3_LBU: value = {24'h000000, byteSel};
            FUNCT3_LH:  value = {{16{halfSel[15]}}, halfSel};
            FUNCT3_LHU: value = {16'h0000, halfSel};
            default:    value = word;
        endcase
    end

endmodule

// File: rtl/wb_regfile_unit.sv
// Writeback stage: selects the W-stage result, commits it to the 32x32
// register file, serves two bypassed read ports and stalls on late loads.
module wb_regfile_unit
    import wb_regfile_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_validW,
    input  logic                  reg_writeW,
    input  logic [1:0]            wb_selW,
    input  logic [REG_ADDR_W-1:0] rdW,
    input  logic [XLEN-1:0]       alu_outW,
    input  logic [XLEN-1:0]       jump_result_plus4W,
    input  logic [2:0]            funct3W,
    input  logic [XLEN-1:0]       mem_rdata,
    input  logic                  mem_resp_valid,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic                  stall,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data
);

    wbState_t              state;
    logic [REG_ADDR_W-1:0] pendRd;
    logic [2:0]            pendFunct3;
    logic [1:0]            pendOff;
    logic                  pendRegWrite;

    logic            inWait;
    logic            loadMiss;
    logic [1:0]      alignOff;
    logic [2:0]      alignFunct3;
    logic [XLEN-1:0] alignedLoad;
    logic [XLEN-1:0] selData;

    logic [XLEN-1:0] regs [NREGS];

    assign inWait   = (state == ST_WAIT_MEM);
    assign loadMiss = !inWait && wb_validW && (wb_selW == WB_SEL_MEM) && !mem_resp_valid;

    // While waiting, the upstream W inputs may change; only the captured
    // offset/size are trusted.
    assign alignOff    = inWait ? pendOff    : alu_outW[1:0];
    assign alignFunct3 = inWait ? pendFunct3 : funct3W;

    wb_regfile_unit_load_align uLoadAlign (
        .word   (mem_rdata),
        .off    (alignOff),
        .funct3 (alignFunct3),
        .value  (alignedLoad)
    );

    always_comb begin
        selData = '0;
        unique case (wb_selW)
            WB_SEL_ALU: selData = alu_outW;
            WB_SEL_MEM: selData = alignedLoad;
            WB_SEL_PC4: selData = jump_result_plus4W;
            default:    selData = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            pendRd       <= '0;
            pendFunct3   <= '0;
            pendOff      <= '0;
            pendRegWrite <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (loadMiss) begin
                        state        <= ST_WAIT_MEM;
                        pendRd       <= rdW;
                        pendFunct3   <= funct3W;
                        pendOff      <= alu_outW[1:0];
                        pendRegWrite <= reg_writeW;
                    end
                end
                ST_WAIT_MEM: begin
                    if (mem_resp_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Gated by rst so stall/wb_en drop the instant reset asserts.
    always_comb begin
        stall   = 1'b0;
        wb_en   = 1'b0;
        wb_rd   = rdW;
        wb_data = selData;
        if (!rst) begin
            if (inWait) begin
                wb_rd   = pendRd;
                wb_data = alignedLoad;
                if (mem_resp_valid) begin
                    wb_en = pendRegWrite;
                end else begin
                    stall = 1'b1;
                end
            end else if (loadMiss) begin
                stall = 1'b1;
            end else begin
                wb_en = wb_validW && reg_writeW && (wb_selW != WB_SEL_RSVD);
            end
        end
    end

    assign regs[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : gRegs
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    regs[gi] <= '0;
                end else if (wb_en && (wb_rd == REG_ADDR_W'(gi))) begin
                    regs[gi] <= wb_data;
                end
            end
        end
    endgenerate

    // Write-first bypass so decode sees the value being committed this cycle.
    assign rs1_data = (rs1_addr == '0) ? '0 :
                      (wb_en && (wb_rd == rs1_addr)) ? wb_data : regs[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 :
                      (wb_en && (wb_rd == rs2_addr)) ? wb_data : regs[rs2_addr];

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Self-checking bench for wb_regfile_unit: directed vector table, late-load
// and reset-during-wait sequences, then randomized transactions vs a model.
module tb_wb_regfile_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_validW, reg_writeW;
    logic [1:0]  wb_selW;
    logic [4:0]  rdW;
    logic [31:0] alu_outW, jump_result_plus4W;
    logic [2:0]  funct3W;
    logic [31:0] mem_rdata;
    logic        mem_resp_valid;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        stall, wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [32];

    always #5 clk = ~clk;

    wb_regfile_unit dut (
        .clk                (clk),
        .rst                (rst),
        .wb_validW          (wb_validW),
        .reg_writeW         (reg_writeW),
        .wb_selW            (wb_selW),
        .rdW                (rdW),
        .alu_outW           (alu_outW),
        .jump_result_plus4W (jump_result_plus4W),
        .funct3W            (funct3W),
        .mem_rdata          (mem_rdata),
        .mem_resp_valid     (mem_resp_valid),
        .rs1_addr           (rs1_addr),
        .rs2_addr           (rs2_addr),
        .rs1_data           (rs1_data),
        .rs2_data           (rs2_data),
        .stall              (stall),
        .wb_en              (wb_en),
        .wb_rd              (wb_rd),
        .wb_data            (wb_data)
    );

    typedef struct {
        logic        valid;
        logic        regw;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [2:0]  f3;
        logic [31:0] mrd;
        logic        expEn;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs [11];

    // Reference load semantics from the ISA description, in plain arithmetic.
    function automatic logic [31:0] loadVal(input logic [31:0] word, input logic [1:0] off,
                                            input logic [2:0] f3);
        logic [31:0] b, h;
        b = (word >> (8 * off)) & 32'hFF;
        h = (word >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] expRead(input logic [4:0] addr, input logic eEn,
                                            input logic [4:0] eRd, input logic [31:0] eData);
        if (addr == 5'd0) return 32'd0;
        if (eEn && eRd == addr) return eData;
        return model[addr];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [2:0] f3, input logic [31:0] mrd, input logic resp,
                         input logic [4:0] a1, input logic [4:0] a2);
        wb_validW = v; reg_writeW = rw; wb_selW = sel; rdW = rd;
        alu_outW = alu; jump_result_plus4W = pc4; funct3W = f3;
        mem_rdata = mrd; mem_resp_valid = resp; rs1_addr = a1; rs2_addr = a2;
    endtask

    // Samples on the falling edge, then commits the expected write to the model.
    task automatic cycleCheck(input string tag, input logic eStall, input logic eEn,
                              input logic [4:0] eRd, input logic [31:0] eData);
        @(negedge clk);
        chk({tag, " stall"}, {31'd0, stall}, {31'd0, eStall});
        chk({tag, " wb_en"}, {31'd0, wb_en}, {31'd0, eEn});
        if (eEn) begin
            chk({tag, " wb_rd"}, {27'd0, wb_rd}, {27'd0, eRd});
            chk({tag, " wb_data"}, wb_data, eData);
        end
        chk({tag, " rs1"}, rs1_data, expRead(rs1_addr, eEn, eRd, eData));
        chk({tag, " rs2"}, rs2_data, expRead(rs2_addr, eEn, eRd, eData));
        $display("txn %s stall=%0b wb_en=%0b wb_rd=%0d wb_data=%08h", tag, stall, wb_en, wb_rd, wb_data);
        @(posedge clk);
        #1;
        if (eEn && eRd != 5'd0) model[eRd] = eData;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        v, rw, isLoad, resp;
        logic [1:0]  sel;
        logic [4:0]  rd, a1, a2;
        logic [31:0] alu, pc4, mrd, eData;
        logic [2:0]  f3;
        int          delay;

        for (int i = 0; i < 32; i++) model[i] = 32'd0;

        vecs[0]  = '{1, 1, 2'b00, 5'd5,  32'h1234_5678, 32'h0,        3'd0, 32'h0,         1, 32'h1234_5678};
        vecs[1]  = '{1, 1, 2'b00, 5'd0,  32'hFFFF_FFFF, 32'h0,        3'd0, 32'h0,         1, 32'hFFFF_FFFF};
        vecs[2]  = '{1, 1, 2'b01, 5'd10, 32'h0000_0003, 32'h0,        3'd0, 32'h80FF_7F01, 1, 32'hFFFF_FF80};
        vecs[3]  = '{1, 1, 2'b01, 5'd11, 32'h0000_0003, 32'h0,        3'd4, 32'h80FF_7F01, 1, 32'h0000_0080};
        vecs[4]  = '{1, 1, 2'b01, 5'd12, 32'h0000_0002, 32'h0,        3'd1, 32'h80FF_7F01, 1, 32'hFFFF_80FF};
        vecs[5]  = '{1, 1, 2'b01, 5'd13, 32'h0000_0000, 32'h0,        3'd5, 32'h80FF_7F01, 1, 32'h0000_7F01};
        vecs[6]  = '{1, 1, 2'b01, 5'd14, 32'h0000_0000, 32'h0,        3'd2, 32'h80FF_7F01, 1, 32'h80FF_7F01};
        vecs[7]  = '{1, 1, 2'b10, 5'd1,  32'h0000_0055, 32'h0000_0104, 3'd0, 32'h0,        1, 32'h0000_0104};
        vecs[8]  = '{1, 1, 2'b11, 5'd2,  32'hAAAA_AAAA, 32'h0000_0200, 3'd0, 32'h0,        0, 32'h0};
        vecs[9]  = '{0, 1, 2'b00, 5'd3,  32'h3333_3333, 32'h0,        3'd0, 32'h0,         0, 32'h0};
        vecs[10] = '{1, 0, 2'b00, 5'd4,  32'h4444_4444, 32'h0,        3'd0, 32'h0,         0, 32'h0};

        // Reset: a load miss presented during reset must not raise stall.
        drive(1, 1, 2'b01, 5'd6, 32'h0, 32'h0, 3'd2, 32'h0, 0, 5'd5, 5'd31);
        cycleCheck("reset", 0, 0, 5'd0, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].valid, vecs[i].regw, vecs[i].sel, vecs[i].rd, vecs[i].alu,
                  vecs[i].pc4, vecs[i].f3, vecs[i].mrd, 1'b1, vecs[i].rd, vecs[i].rd);
            cycleCheck($sformatf("vec%0d", i), 0, vecs[i].expEn, vecs[i].rd, vecs[i].expData);
        end
        // Readbacks of x5/x0, x1/x2 and the load targets.
        drive(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 3'd0, 32'h0, 0, 5'd5, 5'd0);
        cycleCheck("rb_x5_x0", 0, 0, 5'd0, 32'h0);
        drive(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 3'd0, 32'h0, 0, 5'd1, 5'd2);
        cycleCheck("rb_x1_x2", 0, 0, 5'd0, 32'h0);
        drive(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 3'd0, 32'h0, 0, 5'd10, 5'd12);
        cycleCheck("rb_x10_x12", 0, 0, 5'd0, 32'h0);
        chk("x5 value", model[5], 32'h1234_5678);

        // Late LW to x7: three stalled cycles with W inputs churning, then response.
        drive(1, 1, 2'b01, 5'd7, 32'h0000_0000, 32'h0, 3'd2, 32'h1111_1111, 0, 5'd7, 5'd9);
        cycleCheck("late_lw_c1", 1, 0, 5'd0, 32'h0);
        drive(1, 1, 2'b00, 5'd9, 32'h0000_0001, 32'h0, 3'd0, 32'h2222_2222, 0, 5'd7, 5'd9);
        cycleCheck("late_lw_c2", 1, 0, 5'd0, 32'h0);
        drive(1, 0, 2'b10, 5'd9, 32'h0000_0003, 32'h0, 3'd4, 32'h3333_3333, 0, 5'd7, 5'd9);
        cycleCheck("late_lw_c3", 1, 0, 5'd0, 32'h0);
        drive(1, 1, 2'b01, 5'd9, 32'h0000_0003, 32'h0, 3'd0, 32'hCAFE_BABE, 1, 5'd7, 5'd9);
        cycleCheck("late_lw_resp", 0, 1, 5'd7, 32'hCAFE_BABE);
        drive(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 3'd0, 32'h0, 0, 5'd7, 5'd9);
        cycleCheck("late_lw_rb", 0, 0, 5'd0, 32'h0);

        // Late LB with offset 1: the captured offset/size must be used.
        drive(1, 1, 2'b01, 5'd15, 32'h0000_0001, 32'h0, 3'd0, 32'h0, 0, 5'd15, 5'd0);
        cycleCheck("late_lb_c1", 1, 0, 5'd0, 32'h0);
        drive(1, 1, 2'b01, 5'd16, 32'h0000_0002, 32'h0, 3'd2, 32'h0000_8000, 1, 5'd15, 5'd16);
        cycleCheck("late_lb_resp", 0, 1, 5'd15, 32'hFFFF_FF80);

        // Async reset while waiting on a load to x8.
        drive(1, 1, 2'b01, 5'd8, 32'h0, 32'h0, 3'd2, 32'h0, 0, 5'd5, 5'd7);
        cycleCheck("rst_wait_c1", 1, 0, 5'd0, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("rst_wait stall", {31'd0, stall}, 32'd0);
        chk("rst_wait wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_wait x5", rs1_data, 32'd0);
        chk("rst_wait x7", rs2_data, 32'd0);
        $display("txn rst_mid_wait stall=%0b wb_en=%0b", stall, wb_en);
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        @(posedge clk);
        #1;
        drive(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 3'd2, 32'hDEAD_BEEF, 1, 5'd8, 5'd8);
        rst = 1'b0;
        cycleCheck("rst_late_resp", 0, 0, 5'd0, 32'h0);
        drive(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 3'd0, 32'h0, 0, 5'd8, 5'd15);
        cycleCheck("rst_rb_x8", 0, 0, 5'd0, 32'h0);

        // Randomized transactions against the model.
        for (int it = 0; it < 300; it++) begin
            v   = ($urandom % 4) != 0;
            rw  = ($urandom % 4) != 0;
            sel = 2'($urandom % 4);
            rd  = 5'($urandom % 32);
            alu = $urandom;
            pc4 = $urandom;
            f3  = 3'($urandom % 8);
            mrd = $urandom;
            a1  = ($urandom % 2) ? rd : 5'($urandom % 32);
            a2  = ($urandom % 2) ? rd : 5'($urandom % 32);
            isLoad = v && (sel == 2'b01);
            delay  = (isLoad && ($urandom % 3 == 0)) ? int'($urandom_range(1, 4)) : 0;
            if (delay == 0) begin
                resp = isLoad ? 1'b1 : 1'($urandom % 2);
                case (sel)
                    2'b00:   eData = alu;
                    2'b01:   eData = loadVal(mrd, alu[1:0], f3);
                    2'b10:   eData = pc4;
                    default: eData = 32'd0;
                endcase
                drive(v, rw, sel, rd, alu, pc4, f3, mrd, resp, a1, a2);
                cycleCheck($sformatf("rnd%0d", it), 0, v && rw && (sel != 2'b11), rd, eData);
            end else begin
                drive(v, rw, sel, rd, alu, pc4, f3, mrd, 0, a1, a2);
                cycleCheck($sformatf("rnd%0d_miss", it), 1, 0, 5'd0, 32'h0);
                for (int w = 1; w < delay; w++) begin
                    drive(1'($urandom), 1'($urandom), 2'($urandom), 5'($urandom), $urandom,
                          $urandom, 3'($urandom), $urandom, 0, 5'($urandom), rd);
                    cycleCheck($sformatf("rnd%0d_wait%0d", it, w), 1, 0, 5'd0, 32'h0);
                end
                mrd = $urandom;
                drive(1'($urandom), 1'($urandom), 2'($urandom), 5'($urandom), $urandom,
                      $urandom, 3'($urandom), mrd, 1, rd, 5'($urandom));
                cycleCheck($sformatf("rnd%0d_resp", it), 0, rw, rd, loadVal(mrd, alu[1:0], f3));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
